// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial-pattern detector (shift register + comparator).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   din        serial data bit
//   din_valid  din is sampled only when high (low cycles are transparent bubbles)
//   pat_load   load pat_in into the pattern register (din ignored that cycle)
//   pat_in     new pattern, MSB is the first bit received
//   cnt_clr    synchronous clear of match_cnt, wins over a coincident match
//   z          combinational match, same cycle as the last pattern bit
//   z_q        z registered, one cycle later
//   match_cnt  saturating count of matches
module seq_det_param #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int unsigned        HIST_W    = PAT_LEN - 1;
    localparam int unsigned        FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [PAT_LEN-1:0] pat_reg;
    logic [HIST_W-1:0]  hist;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PAT_LEN-1:0] window_c;
    logic               sample_c;
    logic               match_c;

    // Candidate window: held history plus the bit arriving this cycle.
    assign window_c = {hist, din};
    assign sample_c = din_valid & ~pat_load & ~reset;
    assign match_c  = sample_c & (fill == FILL_FULL) & (window_c == pat_reg);
    assign z        = match_c;

    // Fill tracks how many history bits are trustworthy for the current pattern.
    always_comb begin
        fill_nxt = fill;
        if (pat_load) begin
            fill_nxt = '0;
        end else if (din_valid) begin
            if (match_c) begin
                fill_nxt = OVERLAP ? FILL_FULL : '0;
            end else if (fill != FILL_FULL) begin
                fill_nxt = fill + FILL_W'(1);
            end
        end
    end

    // Clear beats increment; increment saturates instead of wrapping.
    always_comb begin
        cnt_nxt = match_cnt;
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (match_c && (match_cnt != CNT_MAX)) begin
            cnt_nxt = match_cnt + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg   <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            z_q       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (pat_load) begin
                pat_reg <= pat_in;
            end else if (din_valid) begin
                hist <= window_c[HIST_W-1:0];
            end
            fill      <= fill_nxt;
            z_q       <= match_c;
            match_cnt <= cnt_nxt;
        end
    end

endmodule
